// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - DMType encodings and FSM state type shared by the dmem responder.
package dmem_responder_pkg;

  localparam logic [2:0] dm_word              = 3'd0;
  localparam logic [2:0] dm_halfword          = 3'd1;
  localparam logic [2:0] dm_halfword_unsigned = 3'd2;
  localparam logic [2:0] dm_byte              = 3'd3;
  localparam logic [2:0] dm_byte_unsigned     = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - DMType lane steering: byte enables, store merge, load extension, fault flags.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  dmtype,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] ram_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        illegal,
  output logic        misaligned
);

  logic [31:0] wdata_lanes;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = addr_lo[1] ? ram_word[31:16] : ram_word[15:0];
  assign byte_sel = 8'(ram_word >> {addr_lo, 3'b000});

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    ld_data     = 32'h0;
    illegal     = 1'b0;
    misaligned  = 1'b0;
    case (dmtype)
      dm_word: begin
        byte_en    = 4'b1111;
        ld_data    = ram_word;
        misaligned = (addr_lo != 2'b00);
      end
      dm_halfword, dm_halfword_unsigned: begin
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        ld_data     = (dmtype == dm_halfword) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'h0, half_sel};
        misaligned  = addr_lo[0];
      end
      dm_byte, dm_byte_unsigned: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        ld_data     = (dmtype == dm_byte) ? {{24{byte_sel[7]}}, byte_sel}
                                          : {24'h0, byte_sel};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Replicated store data lets each lane pick its byte without a shifter.
  always_comb begin
    wr_word = ram_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) wr_word[8*i +: 8] = wdata_lanes[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Latency-programmable data-memory responder; DMEM_MISALIGN_CHK_EN enables misalignment faults.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmtype,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    dmtype_q, dmtype_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [31:0]   mem [0:DEPTH-1];
  logic [31:0]   ram_word;
  logic [31:0]   wr_word;
  logic [31:0]   ld_data;
  logic [3:0]    byte_en;
  logic          illegal;
  logic          misaligned;
  logic          acc_err;
  logic          access;
  logic          ram_we;
  logic          unused_addr_hi;

  // Upper address bits are deliberately dropped so accesses wrap over the RAM.
  assign unused_addr_hi = ^{req_addr[31:AW], byte_en};

  assign ram_word = mem[addr_q[AW-1:2]];

  dmem_lane_align u_align (
    .dmtype     (dmtype_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .ram_word   (ram_word),
    .byte_en    (byte_en),
    .wr_word    (wr_word),
    .ld_data    (ld_data),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

`ifdef DMEM_MISALIGN_CHK_EN
  assign acc_err = illegal | misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign acc_err = illegal;
`endif

  assign access    = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign ram_we    = access && we_q && !acc_err;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dmtype_d    = dmtype_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr[AW-1:0];
          wdata_d  = req_wdata;
          dmtype_d = req_dmtype;
          cnt_d    = 4'(LATENCY - 1);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || we_q) ? 32'h0 : ld_data;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      dmtype_q    <= dm_word;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dmtype_q    <= dmtype_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // RAM has no reset; a reset taken in WAIT leaves state_q at IDLE so no write fires.
  always_ff @(posedge clk) begin
    if (ram_we) mem[addr_q[AW-1:2]] <= wr_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - Table-driven scoreboard bench for dmem_responder.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_dmtype = 3'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dmtype;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_dmtype (req_dmtype),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] dt,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.dmtype = dt;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    exp_t e;
    e.name = v.name; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb_q.push_back(e);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_wdata = v.wdata; req_dmtype = v.dmtype;
  endtask

  // Called at a negedge with a request driven; returns at the negedge after the accept edge.
  task automatic wait_accept(input string name);
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL %s_accept: req_ready never rose", name);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at the negedge after accept; returns at the negedge where rsp_valid is first seen.
  task automatic wait_rsp(input string name, input bit chk_lat);
    int lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); @(negedge clk); lat++; end
    if (!rsp_valid) begin
      checks++; failures++;
      $display("FAIL %s_timeout: rsp_valid never rose", name);
    end else if (chk_lat) begin
      check({name, "_latency"}, lat, LAT);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard: response with empty queue");
      return;
    end
    e = sb_q.pop_front();
    check({e.name, "_rdata"}, rsp_rdata, e.rdata);
    check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit chk_lat);
    @(negedge clk);
    drive_req(v);
    wait_accept(v.name);
    wait_rsp(v.name, chk_lat);
    pop_compare();
    handshake();
    check({v.name, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    vec_t v;

    vecs.push_back(mk("sw_10",       1, 32'h10,   32'h12345678, 3'd0, 32'h0,        0));
    vecs.push_back(mk("sb_13",       1, 32'h13,   32'h00000080, 3'd3, 32'h0,        0));
    vecs.push_back(mk("lb_13",       0, 32'h13,   32'h0,        3'd3, 32'hFFFFFF80, 0));
    vecs.push_back(mk("lbu_13",      0, 32'h13,   32'h0,        3'd4, 32'h00000080, 0));
    vecs.push_back(mk("lw_10_a",     0, 32'h10,   32'h0,        3'd0, 32'h80345678, 0));
    vecs.push_back(mk("sw_10_b",     1, 32'h10,   32'hABCD1234, 3'd0, 32'h0,        0));
    vecs.push_back(mk("lh_12",       0, 32'h12,   32'h0,        3'd1, 32'hFFFFABCD, 0));
    vecs.push_back(mk("lhu_12",      0, 32'h12,   32'h0,        3'd2, 32'h0000ABCD, 0));
    vecs.push_back(mk("sh_10",       1, 32'h10,   32'h00005555, 3'd1, 32'h0,        0));
    vecs.push_back(mk("lw_10_b",     0, 32'h10,   32'h0,        3'd0, 32'hABCD5555, 0));
    vecs.push_back(mk("lb_12",       0, 32'h12,   32'h0,        3'd3, 32'hFFFFFFCD, 0));
    vecs.push_back(mk("lw_wrap",     0, 32'h1010, 32'h0,        3'd0, 32'hABCD5555, 0));
    vecs.push_back(mk("sw_14",       1, 32'h14,   32'hCAFEF00D, 3'd0, 32'h0,        0));
    vecs.push_back(mk("ill_st_14",   1, 32'h14,   32'h11111111, 3'd6, 32'h0,        1));
    vecs.push_back(mk("lw_14",       0, 32'h14,   32'h0,        3'd0, 32'hCAFEF00D, 0));
    vecs.push_back(mk("ill_ld_5",    0, 32'h14,   32'h0,        3'd5, 32'h0,        1));
    vecs.push_back(mk("sbu_11",      1, 32'h11,   32'h000000AA, 3'd4, 32'h0,        0));
    vecs.push_back(mk("lw_10_c",     0, 32'h10,   32'h0,        3'd0, 32'hABCDAA55, 0));
`ifdef DMEM_MISALIGN_CHK_EN
    vecs.push_back(mk("lw_11_mis",   0, 32'h11,   32'h0,        3'd0, 32'h0,        1));
    vecs.push_back(mk("lh_13_mis",   0, 32'h13,   32'h0,        3'd1, 32'h0,        1));
    vecs.push_back(mk("sw_12_mis",   1, 32'h12,   32'h0,        3'd0, 32'h0,        1));
    vecs.push_back(mk("lw_after_mis",0, 32'h10,   32'h0,        3'd0, 32'hABCDAA55, 0));
`else
    vecs.push_back(mk("lw_11_mis",   0, 32'h11,   32'h0,        3'd0, 32'hABCDAA55, 0));
    vecs.push_back(mk("lh_13_mis",   0, 32'h13,   32'h0,        3'd1, 32'hFFFFABCD, 0));
`endif

    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], 1'b1);

    // Backpressure: hold the response while a second request waits.
    @(negedge clk);
    drive_req(mk("bp_lw_10", 0, 32'h10, 32'h0, 3'd0, 32'hABCDAA55, 0));
    wait_accept("bp_lw_10");
    wait_rsp("bp_lw_10", 1'b1);
    held = rsp_rdata;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14; req_dmtype = 3'd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_rdata_hold", rsp_rdata, held);
      check("bp_req_ready_low", 32'(req_ready), 32'd0);
    end
    pop_compare();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    begin
      exp_t e;
      e.name = "bp_lw_14"; e.rdata = 32'hCAFEF00D; e.err = 1'b0;
      sb_q.push_back(e);
    end
    wait_accept("bp_lw_14");
    wait_rsp("bp_lw_14", 1'b1);
    pop_compare();
    handshake();

    // Reset during WAIT must drop the pending store.
    run_vec(mk("sw_18", 1, 32'h18, 32'h01020304, 3'd0, 32'h0, 0), 1'b1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h18;
    req_wdata = 32'hDEADBEEF; req_dmtype = 3'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rw_in_wait", 32'(req_ready), 32'd0);
    rstn = 1'b0;
    #2;
    check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rw_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_vec(mk("lw_18_kept", 0, 32'h18, 32'h0, 3'd0, 32'h01020304, 0), 1'b1);

    v = mk("sb_1b_lbu", 1, 32'h1B, 32'h000000FE, 3'd3, 32'h0, 0);
    run_vec(v, 1'b0);
    run_vec(mk("lw_18_b", 0, 32'h18, 32'h0, 3'd0, 32'hFE020304, 0), 1'b0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
